// File: rtl/trap_unit_if.sv
// ============================================================================
// Module      : trap_unit_if
// Description : Pipeline-side bundle for trap_unit: trap/MRET requests, CSR
//               access port and redirect/status results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface trap_unit_if;
    logic        control_reset;
    logic [3:0]  mcause;
    logic [31:0] trap_pc;
    logic [31:0] trap_value;
    logic        mret;
    logic        csr_valid;
    logic [1:0]  csr_op;
    logic [11:0] csr_address;
    logic [31:0] csr_write_data;
    logic        stall_control;
    logic        retire_valid;
    logic [31:0] csr_read_data;
    logic        csr_illegal;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        interrupt_enable;

    modport master (
        output control_reset, mcause, trap_pc, trap_value, mret,
               csr_valid, csr_op, csr_address, csr_write_data,
               stall_control, retire_valid,
        input  csr_read_data, csr_illegal, redirect_valid, redirect_pc,
               interrupt_enable
    );

    modport slave (
        input  control_reset, mcause, trap_pc, trap_value, mret,
               csr_valid, csr_op, csr_address, csr_write_data,
               stall_control, retire_valid,
        output csr_read_data, csr_illegal, redirect_valid, redirect_pc,
               interrupt_enable
    );
endinterface

`default_nettype wire

// File: rtl/trap_unit.sv
// ============================================================================
// Module      : trap_unit
// Description : Machine-mode trap CSRs, trap entry / MRET redirect FSM.
//               Define TRAP_COUNTERS_EN to add mcycle/minstret counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trap_unit (
    input  logic        clk,
    input  logic        rst,
    trap_unit_if.slave  bus
);
    typedef enum logic [0:0] {IDLE = 1'b0, REDIRECT = 1'b1} state_t;

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MTVAL     = 12'h343;

    state_t      state_q;
    logic        redirect_valid_q;
    logic [31:0] redirect_pc_q;
    logic        mie_q, mpie_q;
    logic [29:0] mtvec_q, mepc_q;
    logic [31:0] mscratch_q, mcause_q, mtval_q;

    logic [31:0] rdata;
    logic        implemented;
    logic [31:0] wdata_d;
    logic        csr_wr;
    logic        take_mret;

`ifdef TRAP_COUNTERS_EN
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
`else
    logic        unused_retire;
    assign unused_retire = bus.retire_valid;
`endif

    always_comb begin
        rdata       = '0;
        implemented = 1'b1;
        case (bus.csr_address)
            ADDR_MSTATUS:   rdata = {19'd0, 2'b11, 3'd0, mpie_q, 3'd0, mie_q, 3'd0};
            ADDR_MTVEC:     rdata = {mtvec_q, 2'b00};
            ADDR_MSCRATCH:  rdata = mscratch_q;
            ADDR_MEPC:      rdata = {mepc_q, 2'b00};
            ADDR_MCAUSE:    rdata = mcause_q;
            ADDR_MTVAL:     rdata = mtval_q;
`ifdef TRAP_COUNTERS_EN
            ADDR_MCYCLE:    rdata = mcycle_q[31:0];
            ADDR_MCYCLEH:   rdata = mcycle_q[63:32];
            ADDR_MINSTRET:  rdata = minstret_q[31:0];
            ADDR_MINSTRETH: rdata = minstret_q[63:32];
`endif
            default:        implemented = 1'b0;
        endcase
    end

    assign bus.csr_read_data    = rdata;
    assign bus.csr_illegal      = bus.csr_valid && !implemented;
    assign bus.redirect_valid   = redirect_valid_q;
    assign bus.redirect_pc      = redirect_pc_q;
    assign bus.interrupt_enable = mie_q;

    always_comb begin
        case (bus.csr_op)
            2'b01:   wdata_d = bus.csr_write_data;
            2'b10:   wdata_d = rdata | bus.csr_write_data;
            2'b11:   wdata_d = rdata & ~bus.csr_write_data;
            default: wdata_d = rdata;
        endcase
    end

    // Set/clear with a zero operand is a pure read and must not disturb state.
    assign csr_wr = bus.csr_valid && !bus.stall_control && implemented &&
                    (state_q == IDLE) && !bus.control_reset &&
                    (bus.csr_op != 2'b00) &&
                    ((bus.csr_op == 2'b01) || (bus.csr_write_data != '0));

    assign take_mret = bus.mret && (state_q == IDLE) && !bus.control_reset;

`ifdef TRAP_COUNTERS_EN
    always_comb begin
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q + {63'd0, bus.retire_valid && !bus.stall_control};
        if (csr_wr) begin
            case (bus.csr_address)
                ADDR_MCYCLE:    mcycle_d   = {mcycle_q[63:32], wdata_d};
                ADDR_MCYCLEH:   mcycle_d   = {wdata_d, mcycle_q[31:0]};
                ADDR_MINSTRET:  minstret_d = {minstret_q[63:32], wdata_d};
                ADDR_MINSTRETH: minstret_d = {wdata_d, minstret_q[31:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else if (bus.control_reset) begin
            state_q          <= REDIRECT;
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= {mtvec_q, 2'b00};
        end else if (take_mret) begin
            state_q          <= REDIRECT;
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= {mepc_q, 2'b00};
        end else begin
            state_q          <= IDLE;
            redirect_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= '0;
            mepc_q     <= '0;
            mscratch_q <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else begin
            if (csr_wr) begin
                case (bus.csr_address)
                    ADDR_MSTATUS: begin
                        mie_q  <= wdata_d[3];
                        mpie_q <= wdata_d[7];
                    end
                    ADDR_MTVEC:    mtvec_q    <= wdata_d[31:2];
                    ADDR_MSCRATCH: mscratch_q <= wdata_d;
                    ADDR_MEPC:     mepc_q     <= wdata_d[31:2];
                    ADDR_MCAUSE:   mcause_q   <= wdata_d;
                    ADDR_MTVAL:    mtval_q    <= wdata_d;
                    default: ;
                endcase
            end
            // Trap/MRET come last so they own mstatus in a shared cycle.
            if (bus.control_reset) begin
                mepc_q   <= bus.trap_pc[31:2];
                mcause_q <= {28'd0, bus.mcause};
                mtval_q  <= bus.trap_value;
                mpie_q   <= mie_q;
                mie_q    <= 1'b0;
            end else if (take_mret) begin
                mie_q  <= mpie_q;
                mpie_q <= 1'b1;
            end
        end
    end

    logic [1:0] unused_pc_lsb;
    assign unused_pc_lsb = bus.trap_pc[1:0];
endmodule

`default_nettype wire

// File: tb/tb_trap_unit.sv
// ============================================================================
// Module      : tb_trap_unit
// Description : Randomized and directed self-checking bench for trap_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_trap_unit;
    logic clk = 1'b0;
    logic rst;
    always #50 clk = ~clk;

    trap_unit_if bus();
    trap_unit dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;

    localparam logic [11:0] ADDRS [10] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342,
                                          12'h343, 12'hB00, 12'hB80, 12'hB02, 12'hB82};

    // Reference model state: architectural view of the CSR file.
    logic        m_mie, m_mpie, m_redir, m_rv;
    logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_rpc;
    logic [63:0] m_cyc, m_ins;

    function automatic bit m_impl(input logic [11:0] a);
        bit counters = 1'b0;
`ifdef TRAP_COUNTERS_EN
        counters = 1'b1;
`endif
        if (a inside {12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343}) return 1'b1;
        if (a inside {12'hB00, 12'hB80, 12'hB02, 12'hB82}) return counters;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        if (!m_impl(a)) return 32'd0;
        case (a)
            12'h300: return 32'h0000_1800 | {24'd0, m_mpie, 3'd0, m_mie, 3'd0};
            12'h305: return m_mtvec & ~32'd3;
            12'h340: return m_mscratch;
            12'h341: return m_mepc & ~32'd3;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'hB00: return m_cyc[31:0];
            12'hB80: return m_cyc[63:32];
            12'hB02: return m_ins[31:0];
            12'hB82: return m_ins[63:32];
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_mie = 0; m_mpie = 0; m_redir = 0; m_rv = 0; m_rpc = 0;
        m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
        m_cyc = 0; m_ins = 0;
    endtask

    // Applies one clock edge worth of architectural effects from current inputs.
    task automatic model_step();
        logic [31:0] old, nv, tvec, epc;
        logic [63:0] c0, i0;
        logic [11:0] a;
        bit wr;
        if (rst) begin model_reset(); return; end
        a = bus.csr_address;
        old = m_read(a);
        tvec = m_mtvec & ~32'd3;
        epc = m_mepc & ~32'd3;
        c0 = m_cyc; i0 = m_ins;
        wr = bus.csr_valid && !bus.stall_control && m_impl(a) && !m_redir &&
             !bus.control_reset && bus.csr_op != 2'd0 &&
             (bus.csr_op == 2'd1 || bus.csr_write_data != 32'd0);
        nv = (bus.csr_op == 2'd1) ? bus.csr_write_data :
             (bus.csr_op == 2'd2) ? (old | bus.csr_write_data) : (old & ~bus.csr_write_data);
        m_cyc = c0 + 1;
        if (bus.retire_valid && !bus.stall_control) m_ins = i0 + 1;
        if (wr) begin
            case (a)
                12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                12'h305: m_mtvec = nv;
                12'h340: m_mscratch = nv;
                12'h341: m_mepc = nv;
                12'h342: m_mcause = nv;
                12'h343: m_mtval = nv;
                12'hB00: m_cyc = {c0[63:32], nv};
                12'hB80: m_cyc = {nv, c0[31:0]};
                12'hB02: m_ins = {i0[63:32], nv};
                12'hB82: m_ins = {nv, i0[31:0]};
                default: ;
            endcase
        end
        if (bus.control_reset) begin
            m_mepc = bus.trap_pc; m_mcause = {28'd0, bus.mcause}; m_mtval = bus.trap_value;
            m_mpie = m_mie; m_mie = 0;
            m_rv = 1; m_rpc = tvec; m_redir = 1;
        end else if (bus.mret && !m_redir) begin
            m_mie = m_mpie; m_mpie = 1;
            m_rv = 1; m_rpc = epc; m_redir = 1;
        end else begin
            m_rv = 0; m_redir = 0;
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.control_reset = 0; bus.mcause = 0; bus.trap_pc = 0; bus.trap_value = 0;
        bus.mret = 0; bus.csr_valid = 0; bus.csr_op = 0; bus.csr_address = 0;
        bus.csr_write_data = 0; bus.stall_control = 0; bus.retire_valid = 0;
    endtask

    task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
        bus.csr_valid = 1; bus.csr_op = op; bus.csr_address = a; bus.csr_write_data = d;
    endtask

    task automatic trap(input logic [3:0] c, input logic [31:0] pc, input logic [31:0] tv);
        bus.control_reset = 1; bus.mcause = c; bus.trap_pc = pc; bus.trap_value = tv;
    endtask

    // Combinational CSR read with no side effect (op none, no clock edge).
    task automatic peek(input logic [11:0] a, output logic [31:0] d, output logic il);
        logic v; logic [1:0] o; logic [11:0] sa;
        v = bus.csr_valid; o = bus.csr_op; sa = bus.csr_address;
        bus.csr_valid = 1; bus.csr_op = 0; bus.csr_address = a;
        #1;
        d = bus.csr_read_data; il = bus.csr_illegal;
        bus.csr_valid = v; bus.csr_op = o; bus.csr_address = sa;
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic il;
        idle(); rst = 1; step(); step(); rst = 0;
        checks++; if (bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL reset_rv got=%b exp=0", bus.redirect_valid); end
        checks++; if (bus.redirect_pc !== 32'd0) begin errors++; $display("FAIL reset_rpc got=%h exp=0", bus.redirect_pc); end
        checks++; if (bus.interrupt_enable !== 1'b0) begin errors++; $display("FAIL reset_ie got=%b exp=0", bus.interrupt_enable); end
        peek(12'h300, d, il);
        checks++; if (d !== 32'h1800) begin errors++; $display("FAIL reset_mstatus got=%h exp=00001800", d); end
        foreach (ADDRS[i]) begin
            peek(ADDRS[i], d, il);
            checks++; if (d !== m_read(ADDRS[i])) begin errors++; $display("FAIL reset_csr_%h got=%h exp=%h", ADDRS[i], d, m_read(ADDRS[i])); end
        end
    endtask

    task automatic test_trap_entry();
        logic [31:0] d; logic il;
        idle(); csr(2'd1, 12'h305, 32'h104); step();
        idle(); trap(4'd4, 32'h80, 32'h1003); step(); idle();
        checks++; if (bus.redirect_valid !== 1'b1) begin errors++; $display("FAIL trap_rv got=%b exp=1", bus.redirect_valid); end
        checks++; if (bus.redirect_pc !== 32'h104) begin errors++; $display("FAIL trap_rpc got=%h exp=00000104", bus.redirect_pc); end
        peek(12'h341, d, il);
        checks++; if (d !== 32'h80) begin errors++; $display("FAIL trap_mepc got=%h exp=00000080", d); end
        peek(12'h342, d, il);
        checks++; if (d !== 32'h4) begin errors++; $display("FAIL trap_mcause got=%h exp=00000004", d); end
        peek(12'h343, d, il);
        checks++; if (d !== 32'h1003) begin errors++; $display("FAIL trap_mtval got=%h exp=00001003", d); end
        step();
        checks++; if (bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL trap_rv_one_cycle got=%b exp=0", bus.redirect_valid); end
    endtask

    task automatic test_mret();
        logic [31:0] d; logic il;
        idle(); csr(2'd2, 12'h300, 32'h8); step(); idle();
        checks++; if (bus.interrupt_enable !== 1'b1) begin errors++; $display("FAIL mret_ie_set got=%b exp=1", bus.interrupt_enable); end
        trap(4'd2, 32'h80, 32'h0); step(); idle();
        checks++; if (bus.interrupt_enable !== 1'b0) begin errors++; $display("FAIL mret_ie_trap got=%b exp=0", bus.interrupt_enable); end
        peek(12'h300, d, il);
        checks++; if (d !== 32'h1880) begin errors++; $display("FAIL mret_mpie got=%h exp=00001880", d); end
        step();
        bus.mret = 1; step(); idle();
        checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h80) begin
            errors++; $display("FAIL mret_redirect got=%b/%h exp=1/00000080", bus.redirect_valid, bus.redirect_pc); end
        checks++; if (bus.interrupt_enable !== 1'b1) begin errors++; $display("FAIL mret_ie got=%b exp=1", bus.interrupt_enable); end
        step();
    endtask

    task automatic test_priority();
        logic [31:0] d; logic il;
        idle(); csr(2'd1, 12'h340, 32'h55); step();
        idle(); trap(4'd2, 32'h200, 32'h0); bus.mret = 1; csr(2'd1, 12'h340, 32'hAA); step(); idle();
        checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h104) begin
            errors++; $display("FAIL prio_redirect got=%b/%h exp=1/00000104", bus.redirect_valid, bus.redirect_pc); end
        peek(12'h340, d, il);
        checks++; if (d !== 32'h55) begin errors++; $display("FAIL prio_mscratch got=%h exp=00000055", d); end
        // Wrong-path MRET and CSR write in the redirect cycle.
        bus.mret = 1; csr(2'd1, 12'h340, 32'h77); step(); idle();
        checks++; if (bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL redir_mret_ignored got=%b exp=0", bus.redirect_valid); end
        peek(12'h340, d, il);
        checks++; if (d !== 32'h55) begin errors++; $display("FAIL redir_write_ignored got=%h exp=00000055", d); end
        trap(4'd1, 32'h200, 32'h0); step(); idle();
        trap(4'd3, 32'h300, 32'h0); step(); idle();
        checks++; if (bus.redirect_valid !== 1'b1) begin errors++; $display("FAIL redir_reenter got=%b exp=1", bus.redirect_valid); end
        peek(12'h341, d, il);
        checks++; if (d !== 32'h300) begin errors++; $display("FAIL redir_reenter_mepc got=%h exp=00000300", d); end
        step();
    endtask

    task automatic test_csr_ops();
        logic [31:0] d; logic il;
        idle(); csr(2'd3, 12'h300, 32'h8); step();
        csr(2'd2, 12'h300, 32'h8); step(); idle();
        peek(12'h300, d, il);
        checks++; if (d[3] !== 1'b1 || bus.interrupt_enable !== 1'b1) begin errors++; $display("FAIL rs_mie got=%b exp=1", d[3]); end
        csr(2'd3, 12'h300, 32'h8); step(); idle();
        peek(12'h300, d, il);
        checks++; if (d[3] !== 1'b0) begin errors++; $display("FAIL rc_mie got=%b exp=0", d[3]); end
        csr(2'd2, 12'h300, 32'h0); step(); csr(2'd3, 12'h340, 32'h0); step(); idle();
        peek(12'h300, d, il);
        checks++; if (d !== m_read(12'h300)) begin errors++; $display("FAIL rs_zero got=%h exp=%h", d, m_read(12'h300)); end
        peek(12'h340, d, il);
        checks++; if (d !== 32'h55) begin errors++; $display("FAIL rc_zero got=%h exp=00000055", d); end
        csr(2'd1, 12'h340, 32'h1234); bus.stall_control = 1; step(); idle();
        peek(12'h340, d, il);
        checks++; if (d !== 32'h55) begin errors++; $display("FAIL stall_write got=%h exp=00000055", d); end
        peek(12'h7FF, d, il);
        checks++; if (il !== 1'b1 || d !== 32'd0) begin errors++; $display("FAIL illegal_7ff got=%b/%h exp=1/00000000", il, d); end
    endtask

    task automatic test_counters();
        logic [31:0] d, h; logic il;
`ifdef TRAP_COUNTERS_EN
        idle(); csr(2'd1, 12'hB00, 32'hFFFF_FFFF); step();
        csr(2'd1, 12'hB80, 32'hFFFF_FFFF); step(); idle();
        peek(12'hB00, d, il); peek(12'hB80, h, il);
        checks++; if ({h, d} !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL cyc_allones got=%h%h exp=ffffffffffffffff", h, d); end
        step();
        peek(12'hB00, d, il); peek(12'hB80, h, il);
        checks++; if ({h, d} !== 64'd0) begin errors++; $display("FAIL cyc_wrap got=%h%h exp=0", h, d); end
        bus.retire_valid = 1; step(); step(); idle();
        peek(12'hB02, d, il);
        checks++; if (d !== m_read(12'hB02)) begin errors++; $display("FAIL instret got=%h exp=%h", d, m_read(12'hB02)); end
`else
        idle();
        peek(12'hB00, d, il);
        checks++; if (il !== 1'b1 || d !== 32'd0) begin errors++; $display("FAIL cyc_illegal got=%b/%h exp=1/00000000", il, d); end
        peek(12'hB82, d, il);
        checks++; if (il !== 1'b1) begin errors++; $display("FAIL instreth_illegal got=%b exp=1", il); end
        step();
`endif
    endtask

    task automatic test_reset_redirect();
        logic [31:0] d; logic il;
        idle(); trap(4'd7, 32'h444, 32'h99); step(); idle();
        checks++; if (bus.redirect_valid !== 1'b1) begin errors++; $display("FAIL rr_pending got=%b exp=1", bus.redirect_valid); end
        rst = 1; step(); rst = 0;
        checks++; if (bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL rr_rv got=%b exp=0", bus.redirect_valid); end
        foreach (ADDRS[i]) begin
            peek(ADDRS[i], d, il);
            checks++; if (d !== m_read(ADDRS[i])) begin errors++; $display("FAIL rr_csr_%h got=%h exp=%h", ADDRS[i], d, m_read(ADDRS[i])); end
        end
        peek(12'h341, d, il);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL rr_mepc got=%h exp=0", d); end
    endtask

    task automatic test_random();
        int k;
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            bus.control_reset = ($urandom_range(0, 7) == 0);
            bus.mcause = 4'($urandom); bus.trap_pc = $urandom; bus.trap_value = $urandom;
            bus.mret = ($urandom_range(0, 7) == 0);
            bus.csr_valid = 1'($urandom_range(0, 1));
            bus.csr_op = 2'($urandom);
            k = $urandom_range(0, 11);
            bus.csr_address = (k < 10) ? ADDRS[k] : (k == 10) ? 12'h7FF : 12'($urandom);
            bus.csr_write_data = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            if (bus.mret && bus.csr_address == 12'h300) bus.csr_valid = 0;
            bus.stall_control = ($urandom_range(0, 3) == 0);
            bus.retire_valid = 1'($urandom_range(0, 1));
            #1;
            checks++; if (bus.csr_illegal !== (bus.csr_valid && !m_impl(bus.csr_address))) begin
                errors++; $display("FAIL rnd_illegal n=%0d got=%b", n, bus.csr_illegal); end
            if (bus.csr_valid) begin
                checks++; if (bus.csr_read_data !== m_read(bus.csr_address)) begin
                    errors++; $display("FAIL rnd_read n=%0d addr=%h got=%h exp=%h", n, bus.csr_address, bus.csr_read_data, m_read(bus.csr_address)); end
            end
            step();
            checks++; if (bus.redirect_valid !== m_rv) begin errors++; $display("FAIL rnd_rv n=%0d got=%b exp=%b", n, bus.redirect_valid, m_rv); end
            if (m_rv) begin
                checks++; if (bus.redirect_pc !== m_rpc) begin errors++; $display("FAIL rnd_rpc n=%0d got=%h exp=%h", n, bus.redirect_pc, m_rpc); end
            end
            checks++; if (bus.interrupt_enable !== m_mie) begin errors++; $display("FAIL rnd_ie n=%0d got=%b exp=%b", n, bus.interrupt_enable, m_mie); end
        end
        rst = 0; idle();
    endtask

    initial begin
        rst = 1;
        model_reset();
        idle();
        test_reset();
        test_trap_entry();
        test_mret();
        test_priority();
        test_csr_ops();
        test_counters();
        test_reset_redirect();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
